core_mem_port: RTL
==================

# core_mem_port

Bus-side memory port of the core. It consumes word-transfer requests from the load/store control stage (`mem_start`, `mem_addr`, `mem_write`, `mem_data_wr`) and runs each one as a single Avalon-MM transaction with waitrequest and pipelined read data. It returns a one-cycle `mem_ready` completion pulse, with read data, that paces the next transfer. It sits between load/store control and the core's data-bus interconnect.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles a transaction may stay outstanding before it is aborted. Used only with `CORE_MEM_TIMEOUT_EN`; range 1..255.

Ports:
- `clk`  in  1  core clock; all logic on posedge.
- `rst`  in  1  reset; synchronous, active-high.
- `mem_start`  in  1  one-cycle request pulse.
- `mem_write`  in  1  1 = store, 0 = load; sampled with `mem_start`.
- `mem_addr`  in  30 (`ptr`)  word address; sampled with `mem_start`.
- `mem_data_wr`  in  32 (`word`)  store data; sampled with `mem_start`.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_data_rd`  out  32  load data; updated only on a load completion, held otherwise.
- `mem_fault`  out  1  qualifies `mem_ready`: the transaction was aborted or got an error response.
- `avl_address`  out  32  byte address, `{addr,2'b00}`.
- `avl_read`, `avl_write`  out  1  command strobes; never both high.
- `avl_writedata`  out  32  store data.
- `avl_byteenable`  out  4  constant `4'b1111`.
- `avl_waitrequest`  in  1  slave stall.
- `avl_readdata`  in  32  read data.
- `avl_readdatavalid`  in  1  read data strobe.
- `avl_response`  in  2  `00` OKAY; any other value is an error. Sampled with `readdatavalid` for reads, and on command acceptance for writes.

## Operation
- Reset values: all outputs 0, except `avl_byteenable` = `4'b1111`. State IDLE, pending slot empty.
- The pending slot is one entry holding {write, addr, data}.
  - `mem_start` in any state loads the slot.
  - A `mem_start` while the slot is already full overwrites it. This is a protocol violation; the bench asserts it never happens.
- FSM states:
  - IDLE: if the slot is full, load the command registers, drive `avl_read` or `avl_write`, clear the slot, and go to CMD.
  - CMD: hold address, data and strobe stable while `avl_waitrequest` = 1. On acceptance (`waitrequest` = 0):
    - Write: drop the strobe, pulse `mem_ready` with `mem_fault = (avl_response != 0)`, and go to IDLE.
    - Read: drop the strobe and go to RDATA.
  - RDATA: on `avl_readdatavalid`, capture `avl_readdata` into `mem_data_rd`, pulse `mem_ready` with `mem_fault = (avl_response != 0)`, and go to IDLE.
- `avl_readdatavalid` outside RDATA is ignored.
- Only one transaction is outstanding at a time.
- Reset in any state forces IDLE on the next edge, drops the strobes and empties the slot. No `mem_ready` is generated for the killed transaction.

## Timing
- All outputs are registered.
- A `mem_start` at edge N while IDLE with the slot empty raises the strobe in cycle N+1.
- Write with zero wait states: `mem_ready` in cycle N+2.
- Read with `readdatavalid` in cycle M: `mem_ready` and `mem_data_rd` valid in cycle M+1.
- Minimum spacing is 2 cycles per write and 3 per read.
- A `mem_start` in the same cycle as `mem_ready` is legal. The slot holds the request, and its strobe rises in the cycle after IDLE is entered.
- `mem_start` in the same cycle that IDLE drains the slot: the new request refills the slot and is issued after the current transaction completes.

## Configuration
- `CORE_MEM_TIMEOUT_EN` defined:
  - An 8-bit counter clears whenever CMD is entered, and increments on each cycle spent in CMD or RDATA.
  - When it reaches `TIMEOUT_CYCLES`, the block drops the strobes, pulses `mem_ready` with `mem_fault` = 1, leaves `mem_data_rd` unchanged, and goes to IDLE.
  - A read timeout sets a discard flag, so the next `avl_readdatavalid` is dropped, even if it arrives during a later read. The flag clears on that strobe or on reset.
- `CORE_MEM_TIMEOUT_EN` undefined: no counter and no discard flag. The block waits indefinitely. `mem_fault` reflects only `avl_response`.

## Structure
- `core/uarch.sv`:
  - holds the enum `mem_port_state` {IDLE, CMD, RDATA};
  - holds the struct `mem_port_req` {write, ptr addr, word data} for the slot;
  - reuses the existing `word` and `ptr` typedefs.
- Sub-module `core_mem_port_timer`: owns the counter, the expiry compare and the discard flag. It exists only under `CORE_MEM_TIMEOUT_EN`.

## Test plan
- Write to 0x0000_0100 with data 0xCAFEF00D and zero waits -> `avl_write` one cycle, `avl_address` = 0x100, `mem_ready` at N+2, `mem_fault` = 0.
- Read from word address 0x40 with 3 waitrequest cycles, then `readdatavalid` 2 cycles later carrying 0x12345678 -> `avl_address` = 0x100 held stable for 4 cycles; `mem_data_rd` = 0x12345678 with `mem_ready`.
- Back-to-back loads with `mem_start` issued in the `mem_ready` cycle -> second strobe follows without loss; no dropped or duplicated `mem_ready`.
- Write with `avl_response` = `10` -> `mem_ready` with `mem_fault` = 1.
- With `CORE_MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 4, a read stuck in waitrequest -> fault completion after 4 cycles; a late `readdatavalid` is discarded and the next read returns its own data.
- `rst` asserted while in RDATA -> strobes drop and no `mem_ready` follows; a stale `readdatavalid` after reset is ignored.

Source files
------------

// File: rtl/core_mem_port_pkg.sv
// core_mem_port_pkg: shared types for the core's bus-side memory port.
//   word           - 32-bit data word
//   ptr            - 30-bit word address
//   mem_port_state - port FSM states
//   mem_port_req   - one pending request {write, addr, data}
package core_mem_port_pkg;

    typedef logic [31:0] word;
    typedef logic [29:0] ptr;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RDATA
    } mem_port_state;

    typedef struct packed {
        logic write;
        ptr   addr;
        word  data;
    } mem_port_req;

    localparam logic [1:0] AVL_RESP_OKAY = 2'b00;
    localparam logic [3:0] AVL_BE_ALL    = 4'b1111;

endpackage

// File: rtl/core_mem_port_timer.sv
// core_mem_port_timer: transaction timeout counter and late-read-data discard flag.
// Built only when CORE_MEM_TIMEOUT_EN is defined.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start        - the port is entering CMD this cycle (clears the counter)
//   active       - the port is in CMD or RDATA (counts)
//   read_abort   - a read is being aborted by timeout (sets the discard flag)
//   rdata_valid  - avl_readdatavalid (clears the discard flag)
//   expired      - this cycle is the TIMEOUT_CYCLES-th outstanding cycle
//   discard      - the next read data strobe belongs to an aborted read
`ifdef CORE_MEM_TIMEOUT_EN
module core_mem_port_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic active,
    input  logic read_abort,
    input  logic rdata_valid,
    output logic expired,
    output logic discard
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       discard_q, discard_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = 8'd0;
        end else if (active) begin
            cnt_d = cnt_q + 8'd1;
        end

        // An abort in the same cycle as a stray strobe still leaves data in flight.
        discard_d = discard_q;
        if (rdata_valid) begin
            discard_d = 1'b0;
        end
        if (read_abort) begin
            discard_d = 1'b1;
        end
    end

    // cnt_q is 0 in the first CMD cycle, so the limit is reached in cycle TIMEOUT_CYCLES.
    assign expired = active && (cnt_q == LAST_COUNT);
    assign discard = discard_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= 8'd0;
            discard_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            discard_q <= discard_d;
        end
    end

endmodule
`endif

// File: rtl/core_mem_port.sv
// core_mem_port: runs one word load/store request at a time as an Avalon-MM
// transaction (waitrequest, pipelined read data) and returns a one-cycle
// mem_ready completion pulse.
// Optional feature macro: CORE_MEM_TIMEOUT_EN (transaction timeout + late data discard).
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   mem_start                 - request pulse; samples mem_write/mem_addr/mem_data_wr
//   mem_ready, mem_fault      - completion pulse and its error qualifier
//   mem_data_rd               - load data, updated only on load completion
//   avl_*                     - Avalon-MM master (registered command side)
module core_mem_port
    import core_mem_port_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_start,
    input  logic        mem_write,
    input  logic [29:0] mem_addr,
    input  logic [31:0] mem_data_wr,
    output logic        mem_ready,
    output logic [31:0] mem_data_rd,
    output logic        mem_fault,
    output logic [31:0] avl_address,
    output logic        avl_read,
    output logic        avl_write,
    output logic [31:0] avl_writedata,
    output logic [3:0]  avl_byteenable,
    input  logic        avl_waitrequest,
    input  logic [31:0] avl_readdata,
    input  logic        avl_readdatavalid,
    input  logic [1:0]  avl_response
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("core_mem_port: TIMEOUT_CYCLES must be in 1..255");
    end

    mem_port_state state_q, state_d;
    mem_port_req   slot_q, slot_d;
    logic          slot_valid_q, slot_valid_d;
    ptr            addr_q, addr_d;
    word           wdata_q, wdata_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic          ready_q, ready_d;
    logic          fault_q, fault_d;
    word           rdata_q, rdata_d;

    logic          enter_cmd;
    logic          read_abort;
    logic          timeout;
    logic          discard;

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        slot_valid_d = slot_valid_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        ready_d      = 1'b0;
        fault_d      = 1'b0;
        rdata_d      = rdata_q;
        enter_cmd    = 1'b0;
        read_abort   = 1'b0;

        case (state_q)
            IDLE: begin
                if (slot_valid_q) begin
                    enter_cmd    = 1'b1;
                    addr_d       = slot_q.addr;
                    wdata_d      = slot_q.data;
                    wr_d         = slot_q.write;
                    rd_d         = !slot_q.write;
                    slot_valid_d = 1'b0;
                    state_d      = CMD;
                end
            end
            CMD: begin
                if (!avl_waitrequest) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (wr_q) begin
                        // Write response is taken on command acceptance.
                        ready_d = 1'b1;
                        fault_d = (avl_response != AVL_RESP_OKAY);
                        state_d = IDLE;
                    end else begin
                        state_d = RDATA;
                    end
                end else if (timeout) begin
                    rd_d       = 1'b0;
                    wr_d       = 1'b0;
                    ready_d    = 1'b1;
                    fault_d    = 1'b1;
                    read_abort = rd_q;
                    state_d    = IDLE;
                end
            end
            RDATA: begin
                if (avl_readdatavalid && !discard) begin
                    rdata_d = avl_readdata;
                    ready_d = 1'b1;
                    fault_d = (avl_response != AVL_RESP_OKAY);
                    state_d = IDLE;
                end else if (timeout) begin
                    ready_d    = 1'b1;
                    fault_d    = 1'b1;
                    read_abort = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                state_d = IDLE;
            end
        endcase

        // A new request always lands in the slot, even while it is being drained.
        if (mem_start) begin
            slot_d.write = mem_write;
            slot_d.addr  = mem_addr;
            slot_d.data  = mem_data_wr;
            slot_valid_d = 1'b1;
        end
    end

`ifdef CORE_MEM_TIMEOUT_EN
    core_mem_port_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .start      (enter_cmd),
        .active     (state_q != IDLE),
        .read_abort (read_abort),
        .rdata_valid(avl_readdatavalid),
        .expired    (timeout),
        .discard    (discard)
    );
`else
    assign timeout = 1'b0;
    assign discard = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            slot_valid_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            slot_valid_q <= slot_valid_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
            rdata_q      <= rdata_d;
        end
    end

    assign mem_ready      = ready_q;
    assign mem_fault      = fault_q;
    assign mem_data_rd    = rdata_q;
    assign avl_address    = {addr_q, 2'b00};
    assign avl_read       = rd_q;
    assign avl_write      = wr_q;
    assign avl_writedata  = wdata_q;
    assign avl_byteenable = AVL_BE_ALL;

endmodule
